ofs_plat_host_chan_burst_splitter: RTL
======================================

Name: ofs_plat_host_chan_burst_splitter

Overview:
- Sits between an AFU request source and a host channel port.
- Splits one multi-line request into host-legal bursts:
  - each burst is at most MAX_BURST_LINES long;
  - no burst crosses a PAGE_BYTES boundary;
  - with the optional feature, each burst is a power of two and naturally aligned.
- Parametrised generalisation of the host channel width/address configuration. Data width, address width, burst limit and page size are all parameters.

Parameters:
- DATA_WIDTH, 512, host channel line width in bits (power of two).
- ADDR_WIDTH_LINES, 42, line-granular address width.
- REQ_LEN_WIDTH, 8, width of in_len. Request length is in_len+1 lines (1..256).
- MAX_BURST_LINES, 4, maximum lines per output burst (power of two, >=1).
- PAGE_BYTES, 4096, no burst may cross this boundary (power of two, >= MAX_BURST_LINES*DATA_WIDTH/8).
- TAG_WIDTH, 8, opaque request tag carried to every burst.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous assert, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  splitter can accept a request.
- in_addr  in  ADDR_WIDTH_LINES  start line address.
- in_len  in  REQ_LEN_WIDTH  length minus one, in lines.
- in_tag  in  TAG_WIDTH  request tag.
- out_valid  out  1  burst valid.
- out_ready  in  1  downstream accepts burst.
- out_addr  out  ADDR_WIDTH_LINES  burst start line.
- out_len  out  $clog2(MAX_BURST_LINES)+1  burst line count (1..MAX_BURST_LINES).
- out_tag  out  TAG_WIDTH  copy of in_tag.
- out_sop  out  1  first burst of the request.
- out_eop  out  1  last burst of the request.

Behaviour:
- Clock/reset: clk is the only clock. reset_n is asynchronous, active-low.
  - While reset_n=0: in_ready=0, out_valid=0, state=IDLE, remaining=0, sop flag=1.
  - out_addr/out_len/out_tag are don't-care while out_valid=0.
- Handshakes: a transfer occurs on valid&&ready at the clk rising edge.
  - out_* are held stable while out_valid=1 && out_ready=0.
- State IDLE:
  - in_ready=1 (after reset release).
  - On in handshake: latch cur_addr=in_addr, remaining=in_len+1 (REQ_LEN_WIDTH+1 bits), tag, sop=1; go to SPLIT.
- State SPLIT:
  - out_valid=1.
  - out_len = min(remaining, MAX_BURST_LINES, PAGE_LINES - cur_addr[log2(PAGE_LINES)-1:0]), where PAGE_LINES = PAGE_BYTES*8/DATA_WIDTH.
  - out_eop = (out_len == remaining). out_sop = sop flag.
  - On out handshake: cur_addr += out_len (modulo 2^ADDR_WIDTH_LINES, wraps silently); remaining -= out_len; sop=0.
  - If eop, return to IDLE.
- Back-to-back requests:
  - in_ready is also 1 in SPLIT during the cycle out_valid && out_ready && out_eop.
  - A request accepted in that cycle loads directly and stays in SPLIT, so there is no bubble.
- Latency: first burst is valid the cycle after in handshake. Throughput is one burst per cycle.
- Outputs are a function of registered state only; there is no combinational in->out path.

Optional Feature:
- OFS_PLAT_HOST_CHAN_BURST_NATURAL_ALIGN_EN:
  - Defined: out_len is further reduced to the largest power of two p <= the computed length such that cur_addr % p == 0.
  - Undefined: any length 1..MAX_BURST_LINES satisfying the page/remaining limits is emitted.

Decomposition:
- Package ofs_plat_host_chan_burst_pkg holds:
  - t_line_addr, t_burst_len, t_req_len typedefs;
  - PAGE_LINES and BURST_LEN_WIDTH localparams;
  - a function computing lines-to-page-boundary.
- Sub-module ofs_plat_host_chan_burst_len_calc: combinational next-burst length from (cur_addr, remaining), including the alignment option.

Test Plan (DATA_WIDTH=512, PAGE_LINES=64, MAX_BURST_LINES=4):
- addr=0x100, in_len=7 -> bursts (0x100,4,sop), (0x104,4,eop).
- addr=0x13E, in_len=3 -> (0x13E,2,sop), (0x140,2,eop); no burst spans the 0x140 page boundary.
- addr=0x101, in_len=3:
  - with _EN: (0x101,1), (0x102,2), (0x104,1);
  - without _EN: single (0x101,4,sop,eop).
- out_ready held low 5 cycles mid-request -> out_* unchanged; then a second request is presented on the eop-handshake cycle -> accepted that cycle, its first burst appears the next cycle.
- reset_n pulled low during burst 2 of 4 -> out_valid=0 immediately (asynchronous); after release in_ready=1 and no residual bursts are emitted.
- addr=2^42-1, in_len=1 -> (2^42-1,1,sop), (0x0,1,eop); the address wraps.

Source files
------------

// File: rtl/ofs_plat_host_chan_burst_pkg.sv
// ofs_plat_host_chan_burst_pkg: shared types, default geometry and page-distance helper for the burst splitter.
package ofs_plat_host_chan_burst_pkg;
    localparam int DEF_DATA_WIDTH = 512;
    localparam int DEF_ADDR_WIDTH_LINES = 42;
    localparam int DEF_REQ_LEN_WIDTH = 8;
    localparam int DEF_MAX_BURST_LINES = 4;
    localparam int DEF_PAGE_BYTES = 4096;
    localparam int PAGE_LINES = DEF_PAGE_BYTES * 8 / DEF_DATA_WIDTH;
    localparam int BURST_LEN_WIDTH = $clog2(DEF_MAX_BURST_LINES) + 1;
    typedef logic [DEF_ADDR_WIDTH_LINES-1:0] t_line_addr;
    typedef logic [BURST_LEN_WIDTH-1:0] t_burst_len;
    typedef logic [DEF_REQ_LEN_WIDTH:0] t_req_len;
    typedef enum logic {IDLE, SPLIT} t_state;
    function automatic int unsigned lines_to_page(input int unsigned addr_low, input int unsigned page_lines);
        return page_lines - (addr_low & (page_lines - 1));
    endfunction
endpackage

// File: rtl/ofs_plat_host_chan_burst_len_calc.sv
// ofs_plat_host_chan_burst_len_calc: next burst length from current address and lines remaining.
// OFS_PLAT_HOST_CHAN_BURST_NATURAL_ALIGN_EN restricts bursts to naturally aligned powers of two.
module ofs_plat_host_chan_burst_len_calc
    import ofs_plat_host_chan_burst_pkg::*;
#(
    parameter int ADDR_WIDTH_LINES = 42,
    parameter int REQ_LEN_WIDTH = 8,
    parameter int MAX_BURST_LINES = 4,
    parameter int N_PAGE_LINES = 64
) (
    input  logic [ADDR_WIDTH_LINES-1:0]          cur_addr,
    input  logic [REQ_LEN_WIDTH:0]               remaining,
    output logic [$clog2(MAX_BURST_LINES):0]     len
);
    localparam int LW = $clog2(MAX_BURST_LINES) + 1;
    localparam int unsigned MAXL = MAX_BURST_LINES;
    int unsigned addr_low, lim;
    always_comb begin
        addr_low = 32'(cur_addr & ADDR_WIDTH_LINES'(N_PAGE_LINES - 1));
        lim = lines_to_page(addr_low, N_PAGE_LINES);
        lim = (32'(remaining) < lim) ? 32'(remaining) : lim;
        lim = (MAXL < lim) ? MAXL : lim;
`ifdef OFS_PLAT_HOST_CHAN_BURST_NATURAL_ALIGN_EN
        len = '0;
        for (int i = 0; i < LW; i++)
            if ((32'd1 << i) <= lim && (addr_low & ((32'd1 << i) - 32'd1)) == 0) len = LW'(32'd1 << i);
`else
        len = LW'(lim);
`endif
    end
endmodule

// File: rtl/ofs_plat_host_chan_burst_splitter.sv
// ofs_plat_host_chan_burst_splitter: splits multi-line requests into page-safe bursts of at most MAX_BURST_LINES.
// OFS_PLAT_HOST_CHAN_BURST_NATURAL_ALIGN_EN (optional) forces naturally aligned power-of-two bursts.
module ofs_plat_host_chan_burst_splitter
    import ofs_plat_host_chan_burst_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH_LINES = 42,
    parameter int REQ_LEN_WIDTH = 8,
    parameter int MAX_BURST_LINES = 4,
    parameter int PAGE_BYTES = 4096,
    parameter int TAG_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [ADDR_WIDTH_LINES-1:0]       in_addr,
    input  logic [REQ_LEN_WIDTH-1:0]          in_len,
    input  logic [TAG_WIDTH-1:0]              in_tag,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ADDR_WIDTH_LINES-1:0]       out_addr,
    output logic [$clog2(MAX_BURST_LINES):0]  out_len,
    output logic [TAG_WIDTH-1:0]              out_tag,
    output logic                              out_sop,
    output logic                              out_eop
);
    localparam int PL = PAGE_BYTES * 8 / DATA_WIDTH;
    localparam int RW = REQ_LEN_WIDTH + 1;
    t_state state, state_n;
    logic [ADDR_WIDTH_LINES-1:0] cur_addr, addr_n;
    logic [RW-1:0] remaining, rem_n;
    logic [TAG_WIDTH-1:0] tag_q, tag_n;
    logic sop_q, sop_n, live;
    ofs_plat_host_chan_burst_len_calc #(
        .ADDR_WIDTH_LINES(ADDR_WIDTH_LINES),
        .REQ_LEN_WIDTH(REQ_LEN_WIDTH),
        .MAX_BURST_LINES(MAX_BURST_LINES),
        .N_PAGE_LINES(PL)
    ) len_calc (
        .cur_addr(cur_addr),
        .remaining(remaining),
        .len(out_len)
    );
    assign out_valid = state == SPLIT;
    assign out_addr = cur_addr;
    assign out_tag = tag_q;
    assign out_sop = sop_q;
    assign out_eop = remaining == RW'(out_len);
    // live keeps in_ready low while reset is held, even though IDLE would otherwise accept
    assign in_ready = live && (!out_valid || (out_ready && out_eop));
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cur_addr <= '0;
            remaining <= '0;
            tag_q <= '0;
            sop_q <= 1'b1;
            live <= 1'b0;
        end else begin
            state <= state_n;
            cur_addr <= addr_n;
            remaining <= rem_n;
            tag_q <= tag_n;
            sop_q <= sop_n;
            live <= 1'b1;
        end
    end
    always_comb begin
        state_n = state;
        addr_n = cur_addr;
        rem_n = remaining;
        tag_n = tag_q;
        sop_n = sop_q;
        if (out_valid && out_ready) begin
            addr_n = cur_addr + ADDR_WIDTH_LINES'(out_len);
            rem_n = remaining - RW'(out_len);
            sop_n = 1'b0;
            if (out_eop) state_n = IDLE;
        end
        if (in_valid && in_ready) begin
            addr_n = in_addr;
            rem_n = RW'(in_len) + RW'(1);
            tag_n = in_tag;
            sop_n = 1'b1;
            state_n = SPLIT;
        end
    end
endmodule
